// File: rtl/pwm_poll_sequencer_if.sv
// Avalon-MM signal bundle shared by the decoder-side master port and the
// CPU-side slave port of pwm_poll_sequencer.
//   address     3   word address
//   read        1   read strobe
//   write       1   write strobe
//   writedata   32  write data
//   readdata    32  read data
//   waitrequest 1   stall from the slave
// The master modport is the bus owner's view and the slave modport is the target's view.
interface pwm_poll_sequencer_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, read, write, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  address, read, write, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/pwm_poll_sequencer.sv
// pwm_poll_sequencer: sweeps the PWM decoder channel registers every POLL_DIV
// cycles, validates each channel tag, and keeps shadow copies plus
// per-channel staleness for the CPU.
//   clock_clk      in   single rising-edge clock
//   reset_reset_n  in   async active-low reset
//   avm_m0         master port to the decoder (read-only use)
//   avs_s0         CPU slave port: 0..5 SHADOW, 6 CONTROL, 7 STATUS
//   irq            out  registered level interrupt
//
// state  | meaning
// IDLE   | waiting for a poll tick
// ISSUE  | read of channel ch outstanding until waitrequest drops
// CHECK  | validate captured word, update shadow/stale, advance
module pwm_poll_sequencer #(
  parameter int NUM_CH       = 6,
  parameter int POLL_DIV     = 50000,
  parameter int STALE_SWEEPS = 8
) (
  input  logic                 clock_clk,
  input  logic                 reset_reset_n,
  pwm_poll_sequencer_if.master avm_m0,
  pwm_poll_sequencer_if.slave  avs_s0,
  output logic                 irq
);

  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] TICK_LOAD = CW'(POLL_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CHECK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ch_q, ch_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   val_q [6];
  logic [15:0]   val_d [6];
  logic          valid_q [6];
  logic          valid_d [6];
  logic [7:0]    scnt_q [6];
  logic [7:0]    scnt_d [6];
  logic          enable_q, enable_d;
  logic          irq_en_q, irq_en_d;
  logic          overrun_q, overrun_d;
  logic          tag_err_q, tag_err_d;
  logic          done_q, done_d;
  logic          irq_q, irq_d;
  logic          tick;
  logic          tag_ok;
  logic          good;
  logic [5:0]    stale;
  logic          unused_ok;

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      rdata_q   <= '0;
      cnt_q     <= TICK_LOAD;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      overrun_q <= 1'b0;
      tag_err_q <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        val_q[i]   <= '0;
        valid_q[i] <= 1'b0;
        scnt_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      overrun_q <= overrun_d;
      tag_err_q <= tag_err_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      val_q     <= val_d;
      valid_q   <= valid_d;
      scnt_q    <= scnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      stale[i] = (i < NUM_CH) && (scnt_q[i] == 8'(STALE_SWEEPS));
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rdata_d   = rdata_q;
    val_d     = val_q;
    valid_d   = valid_q;
    scnt_d    = scnt_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    overrun_d = overrun_q;
    tag_err_d = tag_err_q;
    done_d    = done_q;
    tag_ok    = (rdata_q[31:16] == (16'(ch_q) + 16'd1));
    good      = tag_ok && (rdata_q[15:0] != 16'd0);

    // CPU side first so any hardware set below overrides a same-cycle W1C
    if (avs_s0.write) begin
      if (avs_s0.address == 3'd6) begin
        enable_d = avs_s0.writedata[0];
        irq_en_d = avs_s0.writedata[1];
      end else if (avs_s0.address == 3'd7) begin
        if (avs_s0.writedata[16]) overrun_d = 1'b0;
        if (avs_s0.writedata[9])  done_d    = 1'b0;
        if (avs_s0.writedata[8])  tag_err_d = 1'b0;
      end
    end

    // down-counter reloads on terminal count; held at load while disabled
    tick  = enable_q && (cnt_q == '0);
    cnt_d = (!enable_q || tick) ? TICK_LOAD : cnt_q - 1'b1;
    if (tick && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          ch_d    = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!avm_m0.waitrequest) begin
          rdata_d = avm_m0.readdata;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (good) begin
          val_d[ch_q]   = rdata_q[15:0];
          valid_d[ch_q] = 1'b1;
          scnt_d[ch_q]  = '0;
        end else begin
          if (!tag_ok) tag_err_d = 1'b1;
          if (scnt_q[ch_q] < 8'(STALE_SWEEPS)) scnt_d[ch_q] = scnt_q[ch_q] + 8'd1;
        end
        if (int'(ch_q) == NUM_CH - 1) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (!enable_q) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + 3'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = irq_en_q && (done_q || tag_err_q || overrun_q || (|stale));
  end

  assign avm_m0.read      = (state_q == ST_ISSUE);
  assign avm_m0.address   = ch_q;
  assign avm_m0.write     = 1'b0;
  assign avm_m0.writedata = '0;

  always_comb begin
    avs_s0.readdata = '0;
    case (avs_s0.address)
      3'd6: avs_s0.readdata = {30'b0, irq_en_q, enable_q};
      3'd7: avs_s0.readdata = {15'b0, overrun_q, 6'b0, done_q, tag_err_q, 2'b0, stale};
      default: begin
        if (int'(avs_s0.address) < NUM_CH) begin
          avs_s0.readdata = {valid_q[avs_s0.address], stale[avs_s0.address], 14'b0,
                             val_q[avs_s0.address]};
        end
      end
    endcase
  end

  assign avs_s0.waitrequest = 1'b0;
  assign irq                = irq_q;

  // slave read strobe has no side effect; only a few writedata bits are decoded
  assign unused_ok = ^{avs_s0.read, avs_s0.writedata};

endmodule

// File: tb/tb_pwm_poll_sequencer.sv
module tb_pwm_poll_sequencer;
  localparam int NUM_CH       = 6;
  // period 14 leaves 2 idle cycles per clean sweep, so a 3-cycle stall overruns
  localparam int POLL_DIV     = 14;
  localparam int STALE_SWEEPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  pwm_poll_sequencer_if m0_if ();
  pwm_poll_sequencer_if s0_if ();

  pwm_poll_sequencer #(
    .NUM_CH(NUM_CH), .POLL_DIV(POLL_DIV), .STALE_SWEEPS(STALE_SWEEPS)
  ) u_dut (
    .clock_clk     (clk),
    .reset_reset_n (rst_n),
    .avm_m0        (m0_if),
    .avs_s0        (s0_if),
    .irq           (irq)
  );

  always #50 clk = ~clk;

  // decoder model
  logic [15:0] tag_tb [8];
  logic [15:0] val_tb [8];
  logic [2:0]  stall_ch;
  int          stall_len;
  int          stall_used = 0;

  assign m0_if.waitrequest = m0_if.read && (m0_if.address == stall_ch) && (stall_used < stall_len);
  assign m0_if.readdata    = {tag_tb[m0_if.address], val_tb[m0_if.address]};
  always @(posedge clk) if (m0_if.waitrequest) stall_used <= stall_used + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    s0_if.address   = a;
    s0_if.writedata = d;
    s0_if.write     = 1'b1;
    @(negedge clk);
    s0_if.write     = 1'b0;
  endtask

  task automatic chk_reg(input int a, input logic [31:0] exp);
    logic [31:0] d;
    s0_if.address = 3'(a);
    s0_if.read    = 1'b1;
    #1;
    d = s0_if.readdata;
    s0_if.read    = 1'b0;
    chk($sformatf("reg%0d", a), d, exp);
  endtask

  // returns on the negedge where channel 0 of a fresh sweep is first issued
  task automatic wait_start();
    logic prev;
    bit   seen;
    prev = m0_if.read;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (m0_if.read && m0_if.address == 3'd0 && !prev) seen = 1'b1;
      else prev = m0_if.read;
    end
    if (!seen) chk("sweep_start_timeout", 32'd0, 32'd1);
  endtask

  // returns on the first negedge where the last CHECK's results are visible
  task automatic sweep_wait(input int extra);
    wait_start();
    repeat (12 + extra) @(negedge clk);
  endtask

  logic [11:0] rd_pat;
  logic [17:0] addr_pat, exp_addr;
  logic [14:0] rd_pat15;
  logic [26:0] addr_pat27, exp_addr27;
  int          n;
  int          n_rd;
  int          stall_addrs [9] = '{0, 1, 1, 1, 1, 2, 3, 4, 5};

  initial begin
    s0_if.address = '0; s0_if.read = 1'b0; s0_if.write = 1'b0; s0_if.writedata = '0;
    for (int k = 0; k < 8; k++) begin
      tag_tb[k] = 16'(k + 1);
      val_tb[k] = 16'h0100 + 16'(k);
    end
    stall_ch  = 3'd1;
    stall_len = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(m0_if.read), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 8; a++) chk_reg(a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // first sweep: tick latency, read/address pattern, shadows, irq delay
    cpu_write(3'd6, 32'h3);
    n = 0;
    while (!m0_if.read && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_latency", 32'(n), 32'(POLL_DIV));
    rd_pat = '0; addr_pat = '0; exp_addr = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rd_pat = {rd_pat[10:0], m0_if.read};
      if (m0_if.read) addr_pat = {addr_pat[14:0], m0_if.address};
    end
    for (int k = 0; k < 6; k++) exp_addr = {exp_addr[14:0], 3'(k)};
    chk("read_pattern", 32'(rd_pat), 32'hAAA);
    chk("addr_pattern", 32'(addr_pat), 32'(exp_addr));
    @(negedge clk);
    for (int k = 0; k < 6; k++) chk_reg(k, 32'h8000_0100 + 32'(k));
    chk_reg(6, 32'h3);
    chk_reg(7, 32'h200);
    chk("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_after_done", 32'(irq), 32'd1);

    // tag error on channel 2: shadow held, irq, W1C
    cpu_write(3'd7, 32'h200);
    tag_tb[2] = 16'h0007;
    val_tb[2] = 16'h0555;
    sweep_wait(0);
    chk_reg(2, 32'h8000_0102);
    chk_reg(7, 32'h300);
    chk("irq_tag_err", 32'(irq), 32'd1);
    tag_tb[2] = 16'h0003;
    val_tb[2] = 16'h0102;
    val_tb[4] = 16'h0000;
    cpu_write(3'd7, 32'h300);
    chk_reg(7, 32'h0);
    chk("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'd0);

    // channel 4 value 0: sweep in flight is bad sweep 1; seven more follow
    for (int s = 2; s <= 7; s++) sweep_wait(0);
    chk_reg(4, 32'h8000_0104);
    chk_reg(7, 32'h200);
    sweep_wait(0);
    chk_reg(4, 32'hC000_0104);
    chk_reg(7, 32'h210);
    val_tb[4] = 16'h0444;
    sweep_wait(0);
    chk_reg(4, 32'h8000_0444);
    chk_reg(7, 32'h200);

    // 3-cycle stall on channel 1 -> 15-cycle sweep, overrun
    stall_len = 3;
    wait_start();
    rd_pat15 = '0; addr_pat27 = '0; exp_addr27 = '0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      rd_pat15 = {rd_pat15[13:0], m0_if.read};
      if (m0_if.read) addr_pat27 = {addr_pat27[23:0], m0_if.address};
    end
    for (int k = 0; k < 9; k++) exp_addr27 = {exp_addr27[23:0], 3'(stall_addrs[k])};
    chk("stall_read_pattern", 32'(rd_pat15), 32'(15'b101111010101010));
    chk("stall_addr_pattern", 32'(addr_pat27), 32'(exp_addr27));
    @(negedge clk);
    chk_reg(7, 32'h0001_0200);
    chk_reg(1, 32'h8000_0101);

    // enable cleared while channel 3 is issued
    cpu_write(3'd7, 32'h0001_0300);
    val_tb[3] = 16'h0333;
    val_tb[4] = 16'h0AAA;
    val_tb[5] = 16'h0BBB;
    wait_start();
    repeat (6) @(negedge clk);
    chk("ch3_issue_addr", 32'(m0_if.address), 32'd3);
    chk("ch3_issue_read", 32'(m0_if.read), 32'd1);
    cpu_write(3'd6, 32'h2);
    n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_if.read) n_rd++;
    end
    chk("reads_after_disable", 32'(n_rd), 32'd0);
    chk_reg(3, 32'h8000_0333);
    chk_reg(4, 32'h8000_0444);
    chk_reg(5, 32'h8000_0105);
    chk_reg(7, 32'h0);
    chk_reg(6, 32'h2);
    chk("irq_disabled", 32'(irq), 32'd0);
    cpu_write(3'd0, 32'hFFFF_FFFF);
    chk_reg(0, 32'h8000_0100);

    // async reset in the middle of an ISSUE
    cpu_write(3'd6, 32'h3);
    wait_start();
    repeat (2) @(negedge clk);
    chk("pre_rst_read", 32'(m0_if.read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_read", 32'(m0_if.read), 32'd0);
    chk("async_rst_addr", 32'(m0_if.address), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) chk_reg(a, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    n_rd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_if.read) n_rd++;
    end
    chk("post_rst_no_reads", 32'(n_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
